// File: rtl/coloring_search_engine_if.sv
// rtl/coloring_search_engine_if.sv - control, candidate and result bundle between controller/checker and search engine
interface coloring_search_engine_if #(
    parameter int NUM_VERTICES = 6,
    parameter int COLOR_BITS   = 2
);
    localparam int W = NUM_VERTICES * COLOR_BITS;

    logic         start;
    logic         abort;
    logic [W-1:0] cand_o;
    logic         cand_valid_o;
    logic         check_i;
    logic         busy_o;
    logic         done_o;
    logic         found_o;
    logic [W-1:0] result_o;
    logic [W:0]   tried_o;

    modport master (
        output start, abort, check_i,
        input  cand_o, cand_valid_o, busy_o, done_o, found_o, result_o, tried_o
    );

    modport slave (
        input  start, abort, check_i,
        output cand_o, cand_valid_o, busy_o, done_o, found_o, result_o, tried_o
    );
endinterface

// File: rtl/coloring_search_engine.sv
// rtl/coloring_search_engine.sv - exhaustive mixed-radix colouring enumerator feeding a combinational checker
module coloring_search_engine #(
    parameter int NUM_VERTICES = 6,
    parameter int COLOR_BITS   = 2,
    parameter int NUM_COLORS   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    coloring_search_engine_if.slave  bus
);
    localparam int W = NUM_VERTICES * COLOR_BITS;
    localparam logic [COLOR_BITS-1:0] MAX_DIGIT = COLOR_BITS'(NUM_COLORS - 1);
    localparam logic [COLOR_BITS-1:0] DIGIT_ONE = COLOR_BITS'(1);
    localparam logic [W:0]            TRIED_ONE = (W+1)'(1);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t                state_q, state_d;
    logic [W-1:0]          cand_q, cand_d, result_q, result_d, cand_next;
    logic [W:0]            tried_q, tried_d;
    logic                  cand_valid_q, cand_valid_d;
    logic                  busy_q, busy_d, done_q, done_d, found_q, found_d;
    logic                  last_cand, carry;
    logic [COLOR_BITS-1:0] digit;

    // Vertex 0 is the least-significant digit; a digit at NUM_COLORS-1 wraps and carries.
    always_comb begin
        cand_next = cand_q;
        carry     = 1'b1;
        last_cand = 1'b1;
        digit     = '0;
        for (int v = 0; v < NUM_VERTICES; v++) begin
            digit = cand_q[v*COLOR_BITS +: COLOR_BITS];
            if (digit != MAX_DIGIT) last_cand = 1'b0;
            if (carry) begin
                if (digit == MAX_DIGIT) begin
                    cand_next[v*COLOR_BITS +: COLOR_BITS] = '0;
                end else begin
                    cand_next[v*COLOR_BITS +: COLOR_BITS] = digit + DIGIT_ONE;
                    carry = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        result_d     = result_q;
        tried_d      = tried_q;
        cand_valid_d = cand_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        found_d      = found_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cand_d       = '0;
                    tried_d      = '0;
                    found_d      = 1'b0;
                    result_d     = '0;
                    cand_valid_d = 1'b1;
                    busy_d       = 1'b1;
                    state_d      = SEARCH;
                end
            end
            SEARCH: begin
                if (bus.abort) begin
                    cand_valid_d = 1'b0;
                    busy_d       = 1'b0;
                    found_d      = 1'b0;
                    state_d      = IDLE;
                end else if (bus.check_i || last_cand) begin
                    if (bus.check_i) result_d = cand_q;
                    found_d      = bus.check_i;
                    tried_d      = tried_q + TRIED_ONE;
                    cand_valid_d = 1'b0;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    state_d      = DONE;
                end else begin
                    tried_d = tried_q + TRIED_ONE;
                    cand_d  = cand_next;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cand_q       <= '0;
            result_q     <= '0;
            tried_q      <= '0;
            cand_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            found_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            result_q     <= result_d;
            tried_q      <= tried_d;
            cand_valid_q <= cand_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            found_q      <= found_d;
        end
    end

    assign bus.cand_o       = cand_q;
    assign bus.cand_valid_o = cand_valid_q;
    assign bus.busy_o       = busy_q;
    assign bus.done_o       = done_q;
    assign bus.found_o      = found_q;
    assign bus.result_o     = result_q;
    assign bus.tried_o      = tried_q;
endmodule

// File: tb/tb_coloring_search_engine.sv
// tb/tb_coloring_search_engine.sv - randomized self-checking bench for three colour-count variants
module tb_coloring_search_engine;
    logic        clk = 1'b0;
    logic        rst, start, abort;
    int          mode;
    logic [14:0] emask;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          NCS [3] = '{3, 2, 1};

    logic [11:0] cand_a [3];
    logic [11:0] res_a [3];
    logic [12:0] tried_a [3];
    logic        cv_a [3], busy_a [3], done_a [3], found_a [3];
    int          done_cnt [3] = '{0, 0, 0};
    int          done_cyc [3] = '{0, 0, 0};
    int          bad_cnt [3] = '{0, 0, 0};
    logic [11:0] last_c [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic chk_of(input logic [11:0] c, input int md, input logic [14:0] em);
        int e;
        if (md == 0) return 1'b0;
        if (md == 2) return 1'b1;
        e = 0;
        for (int u = 0; u < 6; u++)
            for (int w = u + 1; w < 6; w++) begin
                if (em[e] && c[2*u +: 2] == c[2*w +: 2]) return 1'b0;
                e++;
            end
        return 1'b1;
    endfunction

    coloring_search_engine_if #(.NUM_VERTICES(6), .COLOR_BITS(2)) ifs0 ();
    coloring_search_engine_if #(.NUM_VERTICES(6), .COLOR_BITS(2)) ifs1 ();
    coloring_search_engine_if #(.NUM_VERTICES(6), .COLOR_BITS(2)) ifs2 ();

    coloring_search_engine #(.NUM_VERTICES(6), .COLOR_BITS(2), .NUM_COLORS(3)) dut0 (.clk(clk), .rst(rst), .bus(ifs0.slave));
    coloring_search_engine #(.NUM_VERTICES(6), .COLOR_BITS(2), .NUM_COLORS(2)) dut1 (.clk(clk), .rst(rst), .bus(ifs1.slave));
    coloring_search_engine #(.NUM_VERTICES(6), .COLOR_BITS(2), .NUM_COLORS(1)) dut2 (.clk(clk), .rst(rst), .bus(ifs2.slave));

    assign ifs0.start = start;  assign ifs1.start = start;  assign ifs2.start = start;
    assign ifs0.abort = abort;  assign ifs1.abort = abort;  assign ifs2.abort = abort;
    assign ifs0.check_i = chk_of(ifs0.cand_o, mode, emask);
    assign ifs1.check_i = chk_of(ifs1.cand_o, mode, emask);
    assign ifs2.check_i = chk_of(ifs2.cand_o, mode, emask);

    assign cand_a[0]  = ifs0.cand_o;       assign cand_a[1]  = ifs1.cand_o;       assign cand_a[2]  = ifs2.cand_o;
    assign res_a[0]   = ifs0.result_o;     assign res_a[1]   = ifs1.result_o;     assign res_a[2]   = ifs2.result_o;
    assign tried_a[0] = ifs0.tried_o;      assign tried_a[1] = ifs1.tried_o;      assign tried_a[2] = ifs2.tried_o;
    assign cv_a[0]    = ifs0.cand_valid_o; assign cv_a[1]    = ifs1.cand_valid_o; assign cv_a[2]    = ifs2.cand_valid_o;
    assign busy_a[0]  = ifs0.busy_o;       assign busy_a[1]  = ifs1.busy_o;       assign busy_a[2]  = ifs2.busy_o;
    assign done_a[0]  = ifs0.done_o;       assign done_a[1]  = ifs1.done_o;       assign done_a[2]  = ifs2.done_o;
    assign found_a[0] = ifs0.found_o;      assign found_a[1] = ifs1.found_o;      assign found_a[2] = ifs2.found_o;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (cv_a[i]) begin
                last_c[i] = cand_a[i];
                for (int v = 0; v < 6; v++)
                    if (int'(cand_a[i][2*v +: 2]) >= NCS[i]) bad_cnt[i]++;
            end
            if (done_a[i]) begin
                done_cnt[i]++;
                done_cyc[i] = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: walk candidate indices in ascending order, decoding digits arithmetically.
    task automatic model(input int nc, input int md, input logic [14:0] em,
                         output int et, output int ef, output logic [11:0] er, output logic [11:0] el);
        int total, p, e, dig [6];
        bit ok;
        total = 1;
        for (int v = 0; v < 6; v++) total *= nc;
        et = total; ef = 0; er = '0; el = '0;
        for (int idx = 0; idx < total; idx++) begin
            p = 1;
            for (int v = 0; v < 6; v++) begin dig[v] = (idx / p) % nc; p *= nc; end
            el = '0;
            for (int v = 0; v < 6; v++) el[2*v +: 2] = 2'(dig[v]);
            ok = (md != 0);
            if (md == 1) begin
                e = 0;
                for (int u = 0; u < 6; u++)
                    for (int w = u + 1; w < 6; w++) begin
                        if (em[e] && dig[u] == dig[w]) ok = 0;
                        e++;
                    end
            end
            if (ok) begin et = idx + 1; ef = 1; er = el; return; end
        end
    endtask

    task automatic run(input int md, input logic [14:0] em);
        int d0 [3], b0 [3], sc, et, ef;
        logic [11:0] er, el;
        bit all_done;
        mode = md; emask = em;
        for (int i = 0; i < 3; i++) begin d0[i] = done_cnt[i]; b0[i] = bad_cnt[i]; end
        @(negedge clk); start = 1'b1; sc = cyc + 1;
        @(negedge clk); start = 1'b0;
        for (int t = 0; t < 1000; t++) begin
            all_done = 1;
            for (int i = 0; i < 3; i++) if (done_cnt[i] == d0[i]) all_done = 0;
            if (all_done) break;
            @(negedge clk);
        end
        mode = 2;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            model(NCS[i], md, em, et, ef, er, el);
            chk($sformatf("tried%0d", i), 32'(tried_a[i]), et);
            chk($sformatf("found%0d", i), 32'(found_a[i]), ef);
            chk($sformatf("result%0d", i), 32'(res_a[i]), 32'(er));
            chk($sformatf("lastcand%0d", i), 32'(last_c[i]), 32'(el));
            chk($sformatf("donecnt%0d", i), done_cnt[i] - d0[i], 1);
            chk($sformatf("donecyc%0d", i), done_cyc[i] - sc + 1, et + 1);
            chk($sformatf("badfield%0d", i), bad_cnt[i] - b0[i], 0);
            chk($sformatf("idle%0d", i), {busy_a[i], cv_a[i], done_a[i]}, 0);
        end
    endtask

    task automatic abort_test(input int a);
        int d0 [3];
        for (int i = 0; i < 3; i++) d0[i] = done_cnt[i];
        mode = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("restart_cand%0d", i), 32'(cand_a[i]), 0);
            chk($sformatf("restart_tried%0d", i), 32'(tried_a[i]), 0);
            chk($sformatf("restart_busy%0d", i), {busy_a[i], cv_a[i]}, 3);
        end
        for (int j = 1; j < a; j++) begin
            start = (j == 2);
            @(negedge clk);
        end
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("abort_tried%0d", i), 32'(tried_a[i]), a - 1);
            chk($sformatf("abort_flags%0d", i), {busy_a[i], cv_a[i], found_a[i], done_a[i]}, 0);
            chk($sformatf("abort_nodone%0d", i), done_cnt[i] - d0[i], 0);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 0; emask = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("rst%0d", i), {cand_a[i], res_a[i], tried_a[i], cv_a[i], busy_a[i], done_a[i], found_a[i]}, 0);
        rst = 1'b0;
        abort = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        chk("idle_abort", {busy_a[0], cv_a[0], tried_a[0]}, 0);

        run(1, 15'h1321);
        chk("graph_res3", 32'(res_a[0]), 32'h044);
        chk("graph_res2", 32'(res_a[1]), 32'h044);
        chk("graph_tried2", 32'(tried_a[1]), 11);
        run(0, 15'h0);
        chk("exh_tried3", 32'(tried_a[0]), 729);
        chk("exh_last3", 32'(last_c[0]), 32'hAAA);
        chk("exh_last2", 32'(last_c[1]), 32'h555);

        abort_test(5);
        abort_test(int'($urandom_range(3, 20)));

        for (int r = 0; r < 6; r++)
            run(int'($urandom_range(0, 2)), 15'($urandom));

        mode = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++)
            chk($sformatf("midrst%0d", i), {cand_a[i], res_a[i], tried_a[i], cv_a[i], busy_a[i], done_a[i], found_a[i]}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/coloring_search_engine.md
Name: coloring_search_engine

Overview:
- Sequential candidate generator that sits directly upstream of the combinational coloring-validity checker.
- Enumerates every colour assignment over NUM_VERTICES vertices, each vertex coloured with NUM_COLORS colours, and drives each assignment onto the checker's packed input bus.
- Samples the checker's single-bit verdict and stops on the first valid colouring, or after the space is exhausted.
- Reports the result, a found flag and the number of candidates tried to the controlling logic.

Parameters:
- NUM_VERTICES, 6, number of graph vertices (digits of the enumeration).
- COLOR_BITS, 2, bits per vertex colour field; the candidate bus is NUM_VERTICES*COLOR_BITS wide.
- NUM_COLORS, 3, colours actually used, 1..2**COLOR_BITS. The enumeration radix is NUM_COLORS.

Ports:
- Clock and reset (already decided): one clock; reset is synchronous and active-high. The ports are named clk and rst.
- clk  input  1  single clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a search; honoured only in IDLE.
- abort  input  1  cancel a running search.
- cand_o  output  NUM_VERTICES*COLOR_BITS  candidate colouring to the checker; vertex v occupies bits [v*COLOR_BITS+COLOR_BITS-1 : v*COLOR_BITS].
- cand_valid_o  output  1  cand_o is being evaluated this cycle.
- check_i  input  1  checker verdict for cand_o (combinational, same cycle); 1 = valid colouring.
- busy_o  output  1  search in progress.
- done_o  output  1  one-cycle pulse when a search completes (found or exhausted).
- found_o  output  1  last completed search found a valid colouring.
- result_o  output  NUM_VERTICES*COLOR_BITS  first valid colouring found; all zeros if none.
- tried_o  output  NUM_VERTICES*COLOR_BITS+1  number of candidates evaluated in the last or current search.

Behaviour:
- FSM states: IDLE, SEARCH, DONE. All outputs are registered.
- Reset (any state, including mid-search):
  - state goes to IDLE.
  - cand_o, result_o and tried_o go to 0.
  - cand_valid_o, busy_o, done_o and found_o go to 0.
- IDLE:
  - start=1 at an edge: cand_o=0, tried_o=0, found_o=0, result_o=0; cand_valid_o=1, busy_o=1; go to SEARCH.
  - abort while in IDLE is ignored.
  - result_o, found_o and tried_o hold their previous values until a start is accepted.
- SEARCH (cand_valid_o=1), each cycle, in priority order:
  - (1) abort=1: go to IDLE with cand_valid_o=0, busy_o=0, found_o=0. done_o is not pulsed. tried_o keeps the count of candidates checked so far.
  - (2) check_i=1: result_o=cand_o, found_o=1, tried_o+=1; go to DONE.
  - (3) cand_o is the last candidate (every digit = NUM_COLORS-1): found_o=0, tried_o+=1; go to DONE.
  - (4) Otherwise: tried_o+=1 and cand_o advances by a mixed-radix increment.
- Mixed-radix increment rules:
  - Vertex 0 is the least-significant digit.
  - A digit equal to NUM_COLORS-1 wraps to 0 and carries into the next vertex.
  - Field codes >= NUM_COLORS are never emitted.
- Enumeration order is therefore ascending in the value sum c_v*NUM_COLORS^v.
- DONE: done_o=1, cand_valid_o=0, busy_o=0 for exactly one cycle; then go to IDLE. start in DONE is ignored.
- Latency: candidate index k is presented in cycle k+1 after the start edge, and done_o is high in cycle k+2. Throughput is one candidate per cycle.
- check_i is ignored whenever cand_valid_o=0.
- Simultaneous start and abort in SEARCH: abort wins and start is ignored.
- NUM_COLORS=1: exactly one candidate (all zeros) is evaluated.

Test Plan:
- Checker enforcing edges (0,1),(1,2),(1,5),(2,3),(3,4); NUM_COLORS=2; start at cycle 0 -> done_o high at cycle 12, found_o=1, result_o=12'h044, tried_o=11.
- Same checker, NUM_COLORS=3 -> found_o=1, result_o=12'h044, tried_o=31, done_o at cycle 32; cand_o never contains field 2'b11.
- check_i tied 0, NUM_COLORS=3 -> tried_o=729; last cand_o=12'hAAA; found_o=0, result_o=0; done_o is a single-cycle pulse at cycle 730.
- check_i tied 0, NUM_COLORS=2 -> tried_o=64, last cand_o=12'h555, found_o=0. Then a second start -> tried_o and cand_o restart from 0.
- Abort at cycle 5 of a K=3 exhaustive search -> IDLE next cycle, busy_o=0, no done_o pulse, found_o=0, tried_o=4. start pulsed while busy has no effect.
- rst asserted mid-search -> all outputs 0 on the next cycle. check_i=1 while IDLE -> no change to any output.
